// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
//   Data-side SRAM responder: slave end of the load/store interface feeding the
//   MEM stage. Accepts at most one request per cycle, commits writes with byte
//   strobes at the accepting edge, and returns responses strictly in order a
//   fixed LATENCY after acceptance as a one-cycle data_ok pulse.
//
// Parameters
//   ADDR_W   word-index bits (depth = 2**ADDR_W 32-bit words)
//   LATENCY  accept-to-data_ok latency, 1..8
//   QDEPTH   maximum outstanding requests, 1..4
//
// Ports
//   clk      clock, all state on posedge
//   resetn   asynchronous active-low reset
//   req      request valid
//   wr       1 = write, 0 = read
//   size     access size (informational; wstrb is authoritative)
//   wstrb    byte-lane write enables, bit i -> wdata[8i+7:8i]
//   addr     byte address; word index = addr[ADDR_W+1:2]
//   wdata    lane-aligned write data
//   addr_ok  request accepted on the coming edge when req & addr_ok
//   data_ok  one-cycle response pulse
//   rdata    read data while data_ok for a read, otherwise 0
// -----------------------------------------------------------------------------
module data_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [2:0] TIMER_INIT = 3'(LATENCY - 1);

  typedef struct packed {
    logic        valid;
    logic        is_read;
    logic [31:0] data;     // read snapshot taken at the accepting edge
    logic [2:0]  timer;    // cycles left until this entry may retire
  } entry_t;

  entry_t             q [QDEPTH];
  logic [31:0]        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic [ADDR_W-1:0]  word_idx;
  logic               accept;
  logic               retire;

  // Address bits outside the word index and the size hint are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign word_idx = addr[ADDR_W+1:2];

  // addr_ok depends only on registered occupancy, never on req.
  assign addr_ok = resetn && (count < CNT_W'(QDEPTH));
  assign accept  = req && addr_ok;

  // The head entry is presented in the cycle its timer reads zero and is
  // popped on the edge that ends that cycle; no back-pressure exists.
  assign retire  = q[rd_ptr].valid && (q[rd_ptr].timer == 3'd0);
  assign data_ok = retire;
  assign rdata   = (retire && q[rd_ptr].is_read) ? q[rd_ptr].data : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the later push below overrides the decrement of its slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (q[i].valid && q[i].timer != 3'd0) q[i].timer <= q[i].timer - 3'd1;
      end

      if (retire) begin
        q[rd_ptr].valid <= 1'b0;
        rd_ptr          <= ptr_inc(rd_ptr);
      end

      // The push slot is always free here: accept implies count < QDEPTH.
      if (accept) begin
        q[wr_ptr] <= '{valid:   1'b1,
                       is_read: !wr,
                       data:    wr ? 32'h0 : mem[word_idx],
                       timer:   TIMER_INIT};
        wr_ptr    <= ptr_inc(wr_ptr);
      end

      case ({accept, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents must survive resetn and
  // a reset branch would turn the RAM into a huge bank of resettable flops.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_data_sram_responder
//   Directed self-checking bench. Two instances share clk/resetn:
//     dut    LATENCY=2, QDEPTH=2  (write/read, strobes, full-stall, reset)
//     dut_b  LATENCY=1, QDEPTH=2  (back-to-back streaming)
//   Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        resetn;

  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  logic        req_b, wr_b;
  logic [1:0]  size_b;
  logic [3:0]  wstrb_b;
  logic [31:0] addr_b, wdata_b;
  logic        addr_ok_b, data_ok_b;
  logic [31:0] rdata_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(10), .LATENCY(2), .QDEPTH(2)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size),
    .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  data_sram_responder #(.ADDR_W(10), .LATENCY(1), .QDEPTH(2)) dut_b (
    .clk(clk), .resetn(resetn), .req(req_b), .wr(wr_b), .size(size_b),
    .wstrb(wstrb_b), .addr(addr_b), .wdata(wdata_b),
    .addr_ok(addr_ok_b), .data_ok(data_ok_b), .rdata(rdata_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Present a request and hold it until accepted (bounded wait).
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    bit done = 1'b0;
    req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s;
    for (int t = 0; t < 16 && !done; t++) begin
      if (addr_ok) done = 1'b1;
      @(negedge clk);
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    req = 1'b0; wr = 1'b0;
  endtask

  // Back-to-back write then read from an empty queue, LATENCY=2, QDEPTH=2.
  task automatic write_read(input string tag, input logic [31:0] wa, input logic [31:0] wd,
                            input logic [3:0] ws, input logic [31:0] ra,
                            input logic [31:0] exp);
    req = 1'b1; wr = 1'b1; addr = wa; wdata = wd; wstrb = ws;
    check({tag, "_aok0"}, 32'(addr_ok), 32'd1);
    check({tag, "_dok0"}, 32'(data_ok), 32'd0);
    @(negedge clk);
    wr = 1'b0; addr = ra; wdata = 32'h0; wstrb = 4'h0;
    check({tag, "_aok1"}, 32'(addr_ok), 32'd1);
    check({tag, "_dok1"}, 32'(data_ok), 32'd0);
    @(negedge clk);
    req = 1'b0;
    check({tag, "_aok_full"}, 32'(addr_ok), 32'd0);
    check({tag, "_dok_wr"}, 32'(data_ok), 32'd1);
    check({tag, "_rdata_wr"}, rdata, 32'h0);
    @(negedge clk);
    check({tag, "_dok_rd"}, 32'(data_ok), 32'd1);
    check({tag, "_rdata_rd"}, rdata, exp);
    @(negedge clk);
    check({tag, "_dok_idle"}, 32'(data_ok), 32'd0);
    check({tag, "_rdata_idle"}, rdata, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    req = 1'b0; wr = 1'b0; size = 2'd2; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
    req_b = 1'b0; wr_b = 1'b0; size_b = 2'd2; wstrb_b = 4'h0; addr_b = 32'h0; wdata_b = 32'h0;

    // T1 reset state
    repeat (2) @(negedge clk);
    check("rst_aok",   32'(addr_ok),   32'd0);
    check("rst_dok",   32'(data_ok),   32'd0);
    check("rst_rdata", rdata,          32'h0);
    check("rst_aok_b", 32'(addr_ok_b), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // T1 full-word write then read
    write_read("t1", 32'h100, 32'h12345678, 4'b1111, 32'h100, 32'h12345678);
    // T2 single-lane write into byte 1
    write_read("t2", 32'h101, 32'h0000AB00, 4'b0010, 32'h100, 32'h1234AB78);
    // T6 all-strobes-off write is a responded no-op
    write_read("t6", 32'h100, 32'hFFFFFFFF, 4'b0000, 32'h100, 32'h1234AB78);

    // T3 preload, then req held for three reads against a 2-deep queue
    send(1'b1, 32'h0, 32'h11111111, 4'hF);
    send(1'b1, 32'h4, 32'h22222222, 4'hF);
    send(1'b1, 32'h8, 32'h33333333, 4'hF);
    repeat (4) @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 32'h0;
    check("t3_aok_a", 32'(addr_ok), 32'd1);
    @(negedge clk);
    addr = 32'h4;
    check("t3_aok_b", 32'(addr_ok), 32'd1);
    check("t3_dok_n1", 32'(data_ok), 32'd0);
    @(negedge clk);
    addr = 32'h8;
    check("t3_aok_stall", 32'(addr_ok), 32'd0);
    check("t3_dok_a", 32'(data_ok), 32'd1);
    check("t3_rdata_a", rdata, 32'h11111111);
    @(negedge clk);
    check("t3_aok_c", 32'(addr_ok), 32'd1);
    check("t3_dok_b", 32'(data_ok), 32'd1);
    check("t3_rdata_b", rdata, 32'h22222222);
    @(negedge clk);
    req = 1'b0;
    check("t3_dok_gap", 32'(data_ok), 32'd0);
    @(negedge clk);
    check("t3_dok_c", 32'(data_ok), 32'd1);
    check("t3_rdata_c", rdata, 32'h33333333);
    @(negedge clk);
    check("t3_dok_end", 32'(data_ok), 32'd0);

    // T4 LATENCY=1 stream: one write then four reads, one per cycle
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t4_aok%0d", k), 32'(addr_ok_b), 32'd1);
      check($sformatf("t4_dok%0d", k), 32'(data_ok_b), (k >= 1) ? 32'd1 : 32'd0);
      check($sformatf("t4_rdata%0d", k), rdata_b, (k >= 2) ? 32'hCAFE0001 : 32'h0);
      if (k == 0) begin
        req_b = 1'b1; wr_b = 1'b1; addr_b = 32'h0; wdata_b = 32'hCAFE0001; wstrb_b = 4'hF;
      end else if (k < 5) begin
        req_b = 1'b1; wr_b = 1'b0; wstrb_b = 4'h0;
      end else begin
        req_b = 1'b0;
      end
      @(negedge clk);
    end
    check("t4_dok_end", 32'(data_ok_b), 32'd0);

    // T5 reset with two reads in flight
    req = 1'b1; wr = 1'b0; addr = 32'h100;
    @(negedge clk);
    addr = 32'h104;
    @(posedge clk);
    #3;
    resetn = 1'b0;
    req = 1'b0;
    #1;
    check("t5_dok_in_rst", 32'(data_ok), 32'd0);
    check("t5_aok_in_rst", 32'(addr_ok), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("t5_dok_post%0d", k), 32'(data_ok), 32'd0);
    end
    check("t5_aok_post", 32'(addr_ok), 32'd1);
    req = 1'b1; wr = 1'b0; addr = 32'h100;
    @(negedge clk);
    req = 1'b0;
    check("t5_dok_n1", 32'(data_ok), 32'd0);
    @(negedge clk);
    check("t5_dok_rd", 32'(data_ok), 32'd1);
    check("t5_rdata_kept", rdata, 32'h1234AB78);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
